// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default width for the counter tracker
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } tracker_state_e;

endpackage

// File: rtl/counter_step_cmp.sv
// rtl/counter_step_cmp.sv - combinational next-sample legality check for a bounce counter
module counter_step_cmp
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic [WIDTH-1:0] last_count,
    input  logic [WIDTH-1:0] sample,
    input  logic             dir,
    output logic             legal,
    output logic             is_turn
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] expected;
    logic             at_bound;

    // Expected successor: step in the current direction, or reverse at the end stop.
    // Boundaries are tested explicitly so a modular wrap can never match.
    always_comb begin
        expected = '0;
        at_bound = 1'b0;
        if (dir) begin
            if (last_count == MAX) begin
                expected = MAX - ONE;
                at_bound = 1'b1;
            end else begin
                expected = last_count + ONE;
            end
        end else begin
            if (last_count == '0) begin
                expected = ONE;
                at_bound = 1'b1;
            end else begin
                expected = last_count - ONE;
            end
        end
        legal   = (sample == expected);
        is_turn = at_bound & legal;
    end

endmodule

// File: rtl/counter_tracker.sv
// rtl/counter_tracker.sv - locks onto a 0..MAX..0 bounce counter; optional TRACKER_PERIOD_CNT_EN period counter
module counter_tracker
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             locked,
    output logic             dir,
    output logic             turn,
    output logic             step_err,
`ifdef TRACKER_PERIOD_CNT_EN
    output logic [7:0]       period_cnt,
`endif
    output logic [WIDTH-1:0] last_count
);

    tracker_state_e   state_q, state_d;
    logic             locked_q, locked_d;
    logic             dir_q, dir_d;
    logic             turn_q, turn_d;
    logic             step_err_q, step_err_d;
    logic [WIDTH-1:0] last_count_q, last_count_d;

    logic cmp_dir;
    logic step_legal;
    logic step_is_turn;
    logic next_dir;

    // ACQ checks against an upward step, which also covers the MAX -> MAX-1 descending lock
    assign cmp_dir = (state_q != DOWN);

    counter_step_cmp #(.WIDTH(WIDTH)) u_step_cmp (
        .last_count (last_count_q),
        .sample     (in_count),
        .dir        (cmp_dir),
        .legal      (step_legal),
        .is_turn    (step_is_turn)
    );

    // Next-state and next-output decode for one accepted sample
    always_comb begin
        state_d      = state_q;
        locked_d     = locked_q;
        dir_d        = dir_q;
        turn_d       = 1'b0;
        step_err_d   = 1'b0;
        last_count_d = last_count_q;
        next_dir     = step_is_turn ? ~cmp_dir : cmp_dir;
        if (in_valid) begin
            last_count_d = in_count;
            if (state_q == IDLE) begin
                state_d = ACQ;
            end else if (step_legal) begin
                state_d  = next_dir ? UP : DOWN;
                locked_d = 1'b1;
                dir_d    = next_dir;
                // A boundary reversal seen while still acquiring is a lock, not a turn
                turn_d   = step_is_turn && (state_q != ACQ);
            end else begin
                state_d    = ACQ;
                locked_d   = 1'b0;
                step_err_d = 1'b1;
            end
        end
    end

`ifdef TRACKER_PERIOD_CNT_EN
    logic [7:0] period_cnt_q, period_cnt_d;
    logic       turn_at_zero;

    assign turn_at_zero = in_valid && (state_q == DOWN) && step_legal && step_is_turn;

    // Count completed periods at the bottom turnaround, saturating
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (turn_at_zero && (period_cnt_q != 8'hFF)) begin
            period_cnt_d = period_cnt_q + 8'd1;
        end
    end

    // Period counter register; survives loss of lock, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_q <= 8'd0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    // Tracker FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            locked_q     <= 1'b0;
            dir_q        <= 1'b1;
            turn_q       <= 1'b0;
            step_err_q   <= 1'b0;
            last_count_q <= '0;
        end else begin
            state_q      <= state_d;
            locked_q     <= locked_d;
            dir_q        <= dir_d;
            turn_q       <= turn_d;
            step_err_q   <= step_err_d;
            last_count_q <= last_count_d;
        end
    end

    assign locked     = locked_q;
    assign dir        = dir_q;
    assign turn       = turn_q;
    assign step_err   = step_err_q;
    assign last_count = last_count_q;

endmodule

// File: tb/tb_counter_tracker.sv
// tb/tb_counter_tracker.sv - directed bench with a behavioural model for counter_tracker
module tb_counter_tracker;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_count;
    logic         locked;
    logic         dir;
    logic         turn;
    logic         step_err;
    logic [W-1:0] last_count;
`ifdef TRACKER_PERIOD_CNT_EN
    logic [7:0]   period_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    counter_tracker #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_count   (in_count),
        .locked     (locked),
        .dir        (dir),
        .turn       (turn),
        .step_err   (step_err),
`ifdef TRACKER_PERIOD_CNT_EN
        .period_cnt (period_cnt),
`endif
        .last_count (last_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a sample is legal when it sits one step from the last one
    // in plain integer arithmetic, in the tracked direction or as the only neighbour
    // at an end stop.
    bit m_have   = 0;
    bit m_locked = 0;
    bit m_dir    = 1;
    bit m_turn   = 0;
    bit m_err    = 0;
    int m_last   = 0;
`ifdef TRACKER_PERIOD_CNT_EN
    int m_period = 0;
`endif

    always @(posedge clk or negedge rst_n) begin
        int  step;
        bit  legal;
        bit  up;
        if (!rst_n) begin
            m_have = 0; m_locked = 0; m_dir = 1; m_turn = 0; m_err = 0; m_last = 0;
`ifdef TRACKER_PERIOD_CNT_EN
            m_period = 0;
`endif
        end else begin
            m_turn = 0;
            m_err  = 0;
            if (in_valid) begin
                if (!m_have) begin
                    m_have = 1;
                end else begin
                    step = int'(in_count) - m_last;
                    if (m_locked && !m_dir)
                        legal = (step == -1) || (m_last == 0 && step == 1);
                    else
                        legal = (step == 1) || (m_last == MAXV && step == -1);
                    if (legal) begin
                        up = (step > 0);
                        if (m_locked && up != m_dir) begin
                            m_turn = 1;
`ifdef TRACKER_PERIOD_CNT_EN
                            if (up && m_period < 255) m_period++;
`endif
                        end
                        m_locked = 1;
                        m_dir    = up;
                    end else begin
                        m_err    = 1;
                        m_locked = 0;
                    end
                end
                m_last = int'(in_count);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cyc_locked", int'(locked), int'(m_locked));
        if (m_locked) chk("cyc_dir", int'(dir), int'(m_dir));
        chk("cyc_turn", int'(turn), int'(m_turn));
        chk("cyc_step_err", int'(step_err), int'(m_err));
        chk("cyc_last_count", int'(last_count), m_last);
`ifdef TRACKER_PERIOD_CNT_EN
        chk("cyc_period_cnt", int'(period_cnt), m_period);
`endif
    end

    task automatic send(input int v);
        in_valid = 1'b1;
        in_count = W'(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_turn", int'(turn), 0);
        chk("rst_step_err", int'(step_err), 0);
        chk("rst_last_count", int'(last_count), 0);
        rst_n = 1'b1;

        // First lock on an upward run
        send(0);  chk("idle_locked", int'(locked), 0); chk("idle_last", int'(last_count), 0);
        send(1);  chk("lock_up_locked", int'(locked), 1); chk("lock_up_dir", int'(dir), 1);
        chk("lock_up_err", int'(step_err), 0);
        send(2);  chk("run_locked", int'(locked), 1); chk("run_last", int'(last_count), 2);

        // Turnaround at MAX
        for (int v = 3; v <= 13; v++) send(v);
        send(14); chk("pre_top_turn", int'(turn), 0);
        send(15); chk("top_turn0", int'(turn), 0); chk("top_dir1", int'(dir), 1);
        send(14); chk("top_turn", int'(turn), 1); chk("top_dir", int'(dir), 0);
        chk("top_locked", int'(locked), 1);
        send(13); chk("post_top_turn", int'(turn), 0); chk("post_top_dir", int'(dir), 0);

        // Turnaround at 0, then MAX->0 wrap is rejected
        for (int v = 12; v >= 0; v--) send(v);
        send(1);  chk("bot_turn", int'(turn), 1); chk("bot_dir", int'(dir), 1);
        for (int v = 2; v <= 15; v++) send(v);
        send(0);  chk("wrap_err", int'(step_err), 1); chk("wrap_locked", int'(locked), 0);
        chk("wrap_last", int'(last_count), 0);
        idle(1);  chk("wrap_err_pulse", int'(step_err), 0);
        send(1);  chk("relock_locked", int'(locked), 1); chk("relock_dir", int'(dir), 1);

        // Repeat sample, illegal ACQ sample, valid gaps
        pulse_reset();
        send(5);  chk("rep_first_err", int'(step_err), 0);
        send(5);  chk("rep_err", int'(step_err), 1); chk("rep_locked", int'(locked), 0);
        send(2);  chk("acq_bad_err", int'(step_err), 1); chk("acq_bad_last", int'(last_count), 2);
        idle(3);  chk("gap_err", int'(step_err), 0); chk("gap_last", int'(last_count), 2);
        send(3);  chk("gap_lock", int'(locked), 1);
        idle(3);  chk("gap_hold_locked", int'(locked), 1); chk("gap_hold_last", int'(last_count), 3);
        send(4);  chk("gap_run_err", int'(step_err), 0); chk("gap_run_last", int'(last_count), 4);

        // Descending lock from MAX, then 0->MAX wrap is rejected
        pulse_reset();
        send(15);
        send(14); chk("dn_lock", int'(locked), 1); chk("dn_dir", int'(dir), 0);
        chk("dn_turn", int'(turn), 0);
        for (int v = 13; v >= 0; v--) send(v);
        send(15); chk("wrap0_err", int'(step_err), 1); chk("wrap0_last", int'(last_count), 15);

        // Asynchronous reset mid-run
        send(14);
        send(13);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_dir", int'(dir), 1);
        chk("arst_last", int'(last_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(7);  chk("post_arst_locked", int'(locked), 0); chk("post_arst_err", int'(step_err), 0);
        chk("post_arst_last", int'(last_count), 7);
        send(8);  chk("post_arst_lock", int'(locked), 1);

`ifdef TRACKER_PERIOD_CNT_EN
        // Period saturation
        pulse_reset();
        send(0);
        for (int p = 0; p < 300; p++) begin
            for (int v = 1; v <= 15; v++) begin
                send(v);
                if (v == 1 && p == 0) chk("period_start", int'(period_cnt), 0);
                if (v == 1 && p == 1) chk("period_one", int'(period_cnt), 1);
            end
            for (int v = 14; v >= 0; v--) send(v);
        end
        send(1);  chk("period_sat", int'(period_cnt), 255);
        send(2);
        #3 rst_n = 1'b0;
        #1;
        chk("period_arst", int'(period_cnt), 0);
        chk("period_arst_locked", int'(locked), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
`endif

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_tracker.md
COUNTER_TRACKER -- requirements
Module: counter_tracker

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the observed counter value; MAX = 2^WIDTH-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_count carries a new sample this cycle.
REQ-005 in_count  input  WIDTH  observed bounce-counter value (0..MAX..0 sequence).
REQ-006 locked  output  1  tracker is synchronised to a legal up or down run.
REQ-007 dir  output  1  current direction: 1 = counting up, 0 = counting down; meaningful only while locked=1.
REQ-008 turn  output  1  one-cycle pulse when a legal turnaround at MAX or 0 is accepted.
REQ-009 step_err  output  1  one-cycle pulse when a sample violates the expected sequence.
REQ-010 last_count  output  WIDTH  most recently accepted sample.
REQ-011 period_cnt  output  8  completed full periods; present only with TRACKER_PERIOD_CNT_EN.

Function
REQ-012 The block SHALL implement FSM states IDLE, ACQ, UP, DOWN.
REQ-013 All outputs SHALL be registered, updating on the clk edge that samples in_valid=1 (latency 1 cycle).
REQ-014 With in_valid=0, the block SHALL hold state, locked, dir, and last_count, and drive turn=0 and step_err=0.
REQ-015 IDLE + valid sample: store it in last_count, go to ACQ, no pulse.
REQ-016 ACQ + sample = last_count+1 (no wrap): go to UP, locked=1, dir=1; if last_count=MAX and sample=MAX-1: go to DOWN, locked=1, dir=0; turn stays 0 in ACQ.
REQ-017 UP: if last_count<MAX, expected = last_count+1; if last_count=MAX, expected = MAX-1, go to DOWN, dir=0, turn=1.
REQ-018 DOWN: if last_count>0, expected = last_count-1; if last_count=0, expected = 1, go to UP, dir=1, turn=1.
REQ-019 Any other sample (including repeat, skip, MAX->0 or 0->MAX wrap): step_err=1, locked=0, go to ACQ; the sample becomes last_count.
REQ-020 In ACQ, an illegal second sample SHALL pulse step_err and remain in ACQ with the new sample stored.
REQ-021 Arithmetic SHALL be WIDTH bits with explicit boundary checks; modular wrap is never accepted as legal.

Reset
REQ-022 On rst_n=0 (asynchronous), state=IDLE, locked=0, dir=1, turn=0, step_err=0, last_count=0, period_cnt=0.
REQ-023 Reset asserted mid-run SHALL abort immediately; the first sample after release is treated as an IDLE sample.

Configuration
REQ-024 Macro TRACKER_PERIOD_CNT_EN: when defined, period_cnt increments on every accepted turn at 0 (DOWN->UP), saturates at 255, and holds across loss of lock.
REQ-025 When TRACKER_PERIOD_CNT_EN is undefined, the period_cnt port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Shared package counter_pkg SHALL hold the FSM state enum (IDLE, ACQ, UP, DOWN) and the default WIDTH constant.
REQ-027 Sub-module counter_step_cmp (combinational: last_count, sample, dir -> legal, is_turn) is the single natural split; the FSM stays in counter_tracker.

Verification
REQ-028 Reset, then samples 0,1,2 -> locked=1 after sample 1, dir=1, no step_err.
REQ-029 Samples 13,14,15,14,13 -> turn=1 exactly on the cycle that accepts 14, then dir=0, locked stays 1.
REQ-030 Locked up run at 15, then sample 0 -> step_err=1 for one cycle, locked=0, state ACQ, last_count=0; then 1 -> relock, dir=1.
REQ-031 Samples 5,5 -> step_err on the second 5; in_valid=0 gaps of 3 cycles in a 2,3,4 run -> no error, outputs held.
REQ-032 With TRACKER_PERIOD_CNT_EN, 300 full 0->15->0 periods -> period_cnt=255 (saturated); rst_n low mid-period -> all outputs at reset values asynchronously.
